match_controller: RTL and testbench
===================================

# match_controller

Frame-rate game sequencer for the head-soccer datapath. It consumes the one-frame goal pulses from the goal detector, keeps both scores and the match clock, and walks the match through kickoff, play, post-goal pause and game-over. Its outputs freeze game objects, re-spawn ball and players, and feed the score/timer overlay.

## Interface
Parameters:
- WIN_SCORE, 5: first player to reach this score ends the match (1..15).
- MATCH_SECONDS, 90: match length in seconds (1..127).
- FRAMES_PER_SEC, 60: clk cycles per displayed second (1..255).
- KICKOFF_FRAMES, 60: freeze length before play resumes (1..255).
- PAUSE_FRAMES, 120: celebration freeze after a goal (1..255).

Ports:
- clk  in  1  frame clock (vsync rate).
- Reset  in  1  asynchronous, active-high.
- start  in  1  level from a synchronised button; its rising edge is detected internally.
- goal_p1  in  1  one-cycle pulse: Player 1 scored.
- goal_p2  in  1  one-cycle pulse: Player 2 scored.
- freeze  out  1  high means ball and player physics hold position.
- respawn  out  1  one-cycle pulse: reload ball and player start positions.
- score_p1, score_p2  out  4 each  current scores.
- time_left  out  7  seconds remaining.
- state  out  3  match_state_t encoding of the current state.
- winner  out  2  00 none, 01 P1, 10 P2, 11 draw.
- game_over  out  1  high in OVER.

## Operation
- Reset values: state IDLE, scores 0, time_left MATCH_SECONDS, freeze 1, respawn 0, winner 00, game_over 0, all counters 0.
- IDLE: freeze=1. A start rising edge clears scores, reloads time_left, zeroes the sub-second counter, pulses respawn, and enters KICKOFF.
- KICKOFF: freeze=1. It lasts exactly KICKOFF_FRAMES cycles, then moves to PLAY.
- PLAY: freeze=0.
  - Sub-second counter counts 0..FRAMES_PER_SEC-1. On wrap, time_left decrements.
  - goal_p1 / goal_p2 increment the matching score, saturating at 15. Both in the same cycle increment both.
  - After any goal, go to OVER if either new score ≥ WIN_SCORE, otherwise go to GOAL_PAUSE.
  - If time_left goes 1→0, go to OVER.
  - A goal and time expiry on the same edge: the goal counts, then OVER.
- GOAL_PAUSE: freeze=1. The match clock and sub-second counter hold, and goals are ignored. It lasts exactly PAUSE_FRAMES cycles, then pulses respawn and enters KICKOFF.
- OVER: freeze=1, game_over=1.
  - winner is set on entry from the final scores: higher score wins, equal scores give 11. It holds until exit.
  - A start rising edge behaves as in IDLE, clears winner to 00 and game_over to 0, and enters KICKOFF.
- Goal pulses outside PLAY are ignored. Start edges outside IDLE/OVER are ignored.
- Frame-count parameters use 8-bit counters. Score comparisons are 4-bit unsigned.

## Timing
- All outputs are registered.
- Scores, time_left, state, winner and game_over update on the clk edge that samples the causing event: latency 1 cycle.
- respawn is high for exactly the first cycle in which state==KICKOFF, whether entered from IDLE, OVER or GOAL_PAUSE.
- freeze drops in the first PLAY cycle. It rises in the same cycle the state leaves PLAY.
- start edge detection uses a 1-cycle delayed copy of start. A start held high at reset release does not count as an edge.
- Reset asserted mid-match forces reset values immediately, with no respawn pulse.

## Structure
- game_pkg: match_state_t enum (IDLE, KICKOFF, PLAY, GOAL_PAUSE, OVER), WINNER_* codes, and the shared SCREEN_W/GOAL_W/FLOOR_Y constants.
- One sub-module, match_clock: sub-second counter plus time_left.
  - Inputs: run, load.
  - Outputs: time_left, expire (a 1-cycle pulse on the 1→0 step).
- The FSM and scores live in match_controller.

## Test plan
Simulation parameters: WIN_SCORE=3, MATCH_SECONDS=5, FRAMES_PER_SEC=4, KICKOFF_FRAMES=2, PAUSE_FRAMES=3.
- Reset then start edge -> respawn is 1 for one cycle, KICKOFF lasts 2 cycles, then PLAY with freeze=0 and time_left=5.
- PLAY with no goals -> time_left reads 4 after 4 cycles. At 20 PLAY cycles, OVER with winner=11 and game_over=1.
- goal_p1 in PLAY -> score_p1=1 next cycle, GOAL_PAUSE for 3 cycles with time_left held, respawn pulse, KICKOFF.
- goal_p1 and goal_p2 in the same cycle with scores 2/2 -> 3/3, OVER, winner=11.
- goal_p2 pulses during GOAL_PAUSE and IDLE -> scores unchanged. Start pulse during PLAY -> no effect.
- Reset asserted mid-PLAY with scores 2/1 -> IDLE immediately, scores 0/0, freeze=1, no respawn pulse.

Source files
------------

// File: rtl/game_pkg.sv
// Shared types and constants for the head-soccer game datapath.
package game_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    KICKOFF    = 3'd1,
    PLAY       = 3'd2,
    GOAL_PAUSE = 3'd3,
    OVER       = 3'd4
  } match_state_t;

  localparam logic [1:0] WINNER_NONE = 2'b00;
  localparam logic [1:0] WINNER_P1   = 2'b01;
  localparam logic [1:0] WINNER_P2   = 2'b10;
  localparam logic [1:0] WINNER_DRAW = 2'b11;

  localparam int SCREEN_W = 640;
  localparam int GOAL_W   = 48;
  localparam int FLOOR_Y  = 400;

endpackage

// File: rtl/match_clock.sv
// Match clock: sub-second frame counter and seconds remaining.
module match_clock
  import game_pkg::*;
#(
  parameter int MATCH_SECONDS  = 90,
  parameter int FRAMES_PER_SEC = 60
) (
  input  logic       clk,
  input  logic       Reset,
  input  logic       run,
  input  logic       load,
  output logic [6:0] time_left,
  output logic       expire
);

  logic [7:0] sub;
  logic       wrap;

  assign wrap   = run && (sub == 8'(FRAMES_PER_SEC - 1));
  // High during the cycle whose closing edge steps time_left 1 -> 0.
  assign expire = wrap && (time_left == 7'd1);

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      sub       <= '0;
      time_left <= 7'(MATCH_SECONDS);
    end else if (load) begin
      sub       <= '0;
      time_left <= 7'(MATCH_SECONDS);
    end else if (run) begin
      if (wrap) begin
        sub <= '0;
        if (time_left != '0)
          time_left <= time_left - 7'd1;
      end else begin
        sub <= sub + 8'd1;
      end
    end
  end

endmodule

// File: rtl/match_controller.sv
// Match sequencer: kickoff/play/pause/over FSM, scores and winner.
module match_controller
  import game_pkg::*;
#(
  parameter int WIN_SCORE      = 5,
  parameter int MATCH_SECONDS  = 90,
  parameter int FRAMES_PER_SEC = 60,
  parameter int KICKOFF_FRAMES = 60,
  parameter int PAUSE_FRAMES   = 120
) (
  input  logic       clk,
  input  logic       Reset,
  input  logic       start,
  input  logic       goal_p1,
  input  logic       goal_p2,
  output logic       freeze,
  output logic       respawn,
  output logic [3:0] score_p1,
  output logic [3:0] score_p2,
  output logic [6:0] time_left,
  output logic [2:0] state,
  output logic [1:0] winner,
  output logic       game_over
);

  match_state_t st, nxt;
  logic [7:0]   cnt, cnt_n;
  logic [3:0]   s1_n, s2_n;
  logic [1:0]   win_n;
  logic         start_q, start_edge;
  logic         clk_load, expire;

  assign start_edge = start && !start_q;
  assign state      = st;

  match_clock #(
    .MATCH_SECONDS (MATCH_SECONDS),
    .FRAMES_PER_SEC(FRAMES_PER_SEC)
  ) u_clock (
    .clk      (clk),
    .Reset    (Reset),
    .run      (st == PLAY),
    .load     (clk_load),
    .time_left(time_left),
    .expire   (expire)
  );

  always_comb begin
    nxt      = st;
    s1_n     = score_p1;
    s2_n     = score_p2;
    win_n    = winner;
    clk_load = 1'b0;
    unique case (st)
      IDLE, OVER: begin
        if (start_edge) begin
          nxt      = KICKOFF;
          s1_n     = '0;
          s2_n     = '0;
          win_n    = WINNER_NONE;
          clk_load = 1'b1;
        end
      end
      KICKOFF: begin
        if (cnt == 8'(KICKOFF_FRAMES - 1))
          nxt = PLAY;
      end
      PLAY: begin
        if (goal_p1 && score_p1 != 4'hf)
          s1_n = score_p1 + 4'd1;
        if (goal_p2 && score_p2 != 4'hf)
          s2_n = score_p2 + 4'd1;
        // A goal on the expiry edge still counts before the match ends.
        if (goal_p1 || goal_p2)
          nxt = (s1_n >= 4'(WIN_SCORE) || s2_n >= 4'(WIN_SCORE))
              ? OVER : GOAL_PAUSE;
        else if (expire)
          nxt = OVER;
      end
      GOAL_PAUSE: begin
        if (cnt == 8'(PAUSE_FRAMES - 1))
          nxt = KICKOFF;
      end
      default: nxt = IDLE;
    endcase

    if (nxt == OVER && st != OVER)
      win_n = (s1_n > s2_n) ? WINNER_P1
            : (s2_n > s1_n) ? WINNER_P2 : WINNER_DRAW;

    cnt_n = '0;
    if (nxt == st && (st == KICKOFF || st == GOAL_PAUSE))
      cnt_n = cnt + 8'd1;
  end

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      st        <= IDLE;
      cnt       <= '0;
      score_p1  <= '0;
      score_p2  <= '0;
      winner    <= WINNER_NONE;
      game_over <= 1'b0;
      freeze    <= 1'b1;
      respawn   <= 1'b0;
      // A button already held at reset release is not a new press.
      start_q   <= 1'b1;
    end else begin
      st        <= nxt;
      cnt       <= cnt_n;
      score_p1  <= s1_n;
      score_p2  <= s2_n;
      winner    <= win_n;
      game_over <= (nxt == OVER);
      freeze    <= (nxt != PLAY);
      respawn   <= (nxt == KICKOFF) && (st != KICKOFF);
      start_q   <= start;
    end
  end

endmodule

// File: tb/tb_match_controller.sv
// Directed bench for match_controller with shortened match parameters.
module tb_match_controller;

  logic       clk = 1'b0;
  logic       Reset;
  logic       start, goal_p1, goal_p2;
  logic       freeze, respawn, game_over;
  logic [3:0] score_p1, score_p2;
  logic [6:0] time_left;
  logic [2:0] state;
  logic [1:0] winner;

  int n_cmp = 0;
  int n_bad = 0;
  int tl;

  match_controller #(
    .WIN_SCORE     (3),
    .MATCH_SECONDS (5),
    .FRAMES_PER_SEC(4),
    .KICKOFF_FRAMES(2),
    .PAUSE_FRAMES  (3)
  ) dut (
    .clk      (clk),
    .Reset    (Reset),
    .start    (start),
    .goal_p1  (goal_p1),
    .goal_p2  (goal_p2),
    .freeze   (freeze),
    .respawn  (respawn),
    .score_p1 (score_p1),
    .score_p2 (score_p2),
    .time_left(time_left),
    .state    (state),
    .winner   (winner),
    .game_over(game_over)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wait_play(input string tag);
    for (int i = 0; i < 20 && state != 3'd2; i++)
      tick();
    check(tag, state, 2);
  endtask

  initial begin
    Reset = 1'b1; start = 1'b0; goal_p1 = 1'b0; goal_p2 = 1'b0;
    tick(); tick();
    check("rst_state", state, 0);
    check("rst_scores", {score_p1, score_p2}, 0);
    check("rst_time", time_left, 5);
    check("rst_freeze", freeze, 1);
    check("rst_respawn", respawn, 0);
    check("rst_winner", winner, 0);
    check("rst_over", game_over, 0);
    Reset = 1'b0;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("ko_state", state, 1);
    check("ko_respawn", respawn, 1);
    check("ko_freeze", freeze, 1);
    tick();
    check("ko2_state", state, 1);
    check("ko2_respawn", respawn, 0);
    tick();
    check("play_state", state, 2);
    check("play_freeze", freeze, 0);
    check("play_time", time_left, 5);
    repeat (3) tick();
    check("time_3f", time_left, 5);
    tick();
    check("time_4f", time_left, 4);
    repeat (15) tick();
    check("time_19f", time_left, 1);
    check("state_19f", state, 2);
    tick();
    check("exp_state", state, 4);
    check("exp_time", time_left, 0);
    check("exp_winner", winner, 3);
    check("exp_over", game_over, 1);
    check("exp_freeze", freeze, 1);

    start = 1'b1;
    tick();
    start = 1'b0;
    check("rs_state", state, 1);
    check("rs_respawn", respawn, 1);
    check("rs_winner", winner, 0);
    check("rs_over", game_over, 0);
    check("rs_time", time_left, 5);
    repeat (2) tick();
    check("rs_play", state, 2);

    start = 1'b1;
    tick();
    start = 1'b0;
    check("play_start_state", state, 2);
    check("play_start_resp", respawn, 0);
    tick();

    goal_p1 = 1'b1;
    tick();
    goal_p1 = 1'b0;
    check("g1_score", score_p1, 1);
    check("g1_state", state, 3);
    check("g1_freeze", freeze, 1);
    tl = time_left;
    goal_p2 = 1'b1;
    tick();
    goal_p2 = 1'b0;
    check("gp_p2_ignored", score_p2, 0);
    check("gp_time1", time_left, tl);
    tick();
    check("gp_state3", state, 3);
    check("gp_time2", time_left, tl);
    tick();
    check("gp_ko", state, 1);
    check("gp_respawn", respawn, 1);
    check("gp_time3", time_left, tl);
    wait_play("gp_play");

    goal_p1 = 1'b1; goal_p2 = 1'b1;
    tick();
    goal_p1 = 1'b0; goal_p2 = 1'b0;
    check("both1", {score_p1, score_p2}, 8'h21);
    check("both1_state", state, 3);
    wait_play("both1_play");
    goal_p2 = 1'b1;
    tick();
    goal_p2 = 1'b0;
    check("g22", {score_p1, score_p2}, 8'h22);
    wait_play("g22_play");
    goal_p1 = 1'b1; goal_p2 = 1'b1;
    tick();
    goal_p1 = 1'b0; goal_p2 = 1'b0;
    check("both33", {score_p1, score_p2}, 8'h33);
    check("both33_state", state, 4);
    check("both33_winner", winner, 3);
    check("both33_over", game_over, 1);
    goal_p2 = 1'b1;
    tick();
    goal_p2 = 1'b0;
    check("over_p2_ignored", score_p2, 3);

    start = 1'b1;
    tick();
    start = 1'b0;
    wait_play("r2_play");
    goal_p1 = 1'b1; goal_p2 = 1'b1;
    tick();
    goal_p1 = 1'b0; goal_p2 = 1'b0;
    wait_play("r2_play2");
    goal_p1 = 1'b1;
    tick();
    goal_p1 = 1'b0;
    wait_play("r2_play3");
    check("r2_scores", {score_p1, score_p2}, 8'h21);
    Reset = 1'b1;
    #1;
    check("mid_rst_state", state, 0);
    check("mid_rst_scores", {score_p1, score_p2}, 0);
    check("mid_rst_freeze", freeze, 1);
    check("mid_rst_respawn", respawn, 0);
    tick();
    Reset = 1'b0;
    goal_p2 = 1'b1;
    tick();
    goal_p2 = 1'b0;
    check("idle_p2_ignored", score_p2, 0);
    check("idle_state", state, 0);
    check("idle_respawn", respawn, 0);

    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      wait_play("p2w_play");
      goal_p2 = 1'b1;
      tick();
      goal_p2 = 1'b0;
    end
    check("p2w_score", score_p2, 3);
    check("p2w_state", state, 4);
    check("p2w_winner", winner, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
